// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    // Operand/sum width used when no override is given.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Controller states; busy/done are decoded directly from these.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-counter width: enough to count 0..w-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  Sum,
        input  Cout
    );

    // Adder side: accepts operands, reports status and result.
    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output Sum,
        output Cout
    );

endinterface : serial_adder_if

// File: rtl/serial_adder_fa.sv
// One-bit full adder used for each serial step.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic Sum,
    output logic Cout
);

    // Sum and carry of three single-bit inputs.
    always_comb begin
        Sum  = a ^ b ^ cin;
        Cout = (a & b) | (cin & (a ^ b));
    end

endmodule : fa

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] a_sr_d;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] b_sr_d;
    logic [WIDTH-1:0] sum_sr_q;
    logic [WIDTH-1:0] sum_sr_d;
    logic             carry_q;
    logic             carry_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;

    logic             start_acc_c;
    logic             last_step_c;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy_c;
    logic             done_c;

    // Per-bit adder working on the current LSBs and the running carry.
    fa u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Start is honoured only when no addition is in flight.
    always_comb begin
        start_acc_c = bus.start && ((state_q == IDLE) || (state_q == DONE));
        last_step_c = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    if (bus.start) state_d = SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        unique case (state_q)
            SHIFT:   busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand load on start, one shift/add step per SHIFT cycle.
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        if (start_acc_c) begin
            a_sr_d   = bus.a;
            b_sr_d   = bus.b;
            sum_sr_d = '0;
            carry_d  = bus.cin;
            cnt_d    = '0;
        end else if (state_q == SHIFT) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = (sum_sr_q >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};
            carry_d  = fa_cout;
            if (last_step_c) begin
                // Counter parks at zero so it never runs past WIDTH-1.
                cnt_d  = '0;
                sum_d  = (sum_sr_q >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};
                cout_d = fa_cout;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [31:0] prev_sum  [2];
    logic        prev_cout [2];

    logic [7:0]  bb_a [4];
    logic [7:0]  bb_b [4];
    logic        bb_c [4];

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rd_busy(input int sel);
        return (sel == 0) ? if8.busy : if16.busy;
    endfunction

    function automatic logic rd_done(input int sel);
        return (sel == 0) ? if8.done : if16.done;
    endfunction

    function automatic logic [31:0] rd_sum(input int sel);
        return (sel == 0) ? 32'(if8.Sum) : 32'(if16.Sum);
    endfunction

    function automatic logic rd_cout(input int sel);
        return (sel == 0) ? if8.Cout : if16.Cout;
    endfunction

    task automatic check_state(input int sel, input string tag, input logic eb, input logic ed,
                               input logic [31:0] es, input logic ec);
        check({tag, "_busy"}, 33'(rd_busy(sel)), 33'(eb));
        check({tag, "_done"}, 33'(rd_done(sel)), 33'(ed));
        check({tag, "_sum"},  33'(rd_sum(sel)),  33'(es));
        check({tag, "_cout"}, 33'(rd_cout(sel)), 33'(ec));
    endtask

    task automatic drive(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        if (sel == 0) begin
            if8.start = s;
            if8.a     = a[7:0];
            if8.b     = b[7:0];
            if8.cin   = c;
        end else begin
            if16.start = s;
            if16.a     = a[15:0];
            if16.b     = b[15:0];
            if16.cin   = c;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One addition; expected result from plain integer arithmetic.
    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input bit full, input int glitch_k, input string tag);
        int          w;
        logic [31:0] mask;
        logic [32:0] total;
        logic [31:0] es;
        logic        ec;
        w     = (sel == 0) ? 8 : 16;
        mask  = (sel == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
        total = 33'(a & mask) + 33'(b & mask) + 33'(c);
        es    = total[31:0] & mask;
        ec    = total[w];
        drive(sel, 1'b1, a, b, c);
        tick();
        drive(sel, 1'b0, $urandom, $urandom, 1'($urandom));
        if (full) check_state(sel, {tag, "_acc"}, 1'b1, 1'b0, prev_sum[sel], prev_cout[sel]);
        for (int k = 1; k < w; k++) begin
            if (k == glitch_k) drive(sel, 1'b1, ~a, b ^ 32'h0000_0005, ~c);
            tick();
            drive(sel, 1'b0, $urandom, $urandom, 1'($urandom));
            if (full || k == w - 1)
                check_state(sel, {tag, "_shift"}, 1'b1, 1'b0, prev_sum[sel], prev_cout[sel]);
        end
        tick();
        check_state(sel, {tag, "_res"}, 1'b0, 1'b1, es, ec);
        prev_sum[sel]  = es;
        prev_cout[sel] = ec;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
        prev_sum[0]  = 32'h0;
        prev_sum[1]  = 32'h0;
        prev_cout[0] = 1'b0;
        prev_cout[1] = 1'b0;
        tick();
        tick();
        check_state(0, "reset8", 1'b0, 1'b0, 32'h0, 1'b0);
        check_state(1, "reset16", 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        tick();
        check_state(0, "idle8", 1'b0, 1'b0, 32'h0, 1'b0);

        // Directed corner operands.
        do_op(0, 32'hFF, 32'h01, 1'b0, 1'b1, -1, "ff_01");
        do_op(0, 32'h5A, 32'hA5, 1'b1, 1'b1, -1, "5a_a5_c1");
        do_op(0, 32'h00, 32'h00, 1'b0, 1'b1, -1, "zero");
        do_op(0, 32'h3C, 32'h4B, 1'b0, 1'b1, 3, "ignored_start");

        // Reset mid-addition abandons the result.
        drive(0, 1'b1, 32'hC3, 32'h7E, 1'b1);
        tick();
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        check(0 == 0 ? "pre_rst_busy" : "", 33'(if8.busy), 33'(1'b1));
        rst = 1'b1;
        #1;
        check_state(0, "mid_rst", 1'b0, 1'b0, 32'h0, 1'b0);
        prev_sum[0]  = 32'h0;
        prev_cout[0] = 1'b0;
        prev_sum[1]  = 32'h0;
        prev_cout[1] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_state(0, "post_rst", 1'b0, 1'b0, 32'h0, 1'b0);
        do_op(0, 32'h10, 32'h20, 1'b0, 1'b1, -1, "after_rst");

        // Start held high: back-to-back additions, done for one cycle each.
        bb_a[0] = 8'hFF;
        bb_b[0] = 8'hFF;
        bb_c[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            bb_a[i] = 8'($urandom);
            bb_b[i] = 8'($urandom);
            bb_c[i] = 1'($urandom);
        end
        drive(0, 1'b1, 32'(bb_a[0]), 32'(bb_b[0]), bb_c[0]);
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [8:0] t;
            t = 9'(bb_a[i]) + 9'(bb_b[i]) + 9'(bb_c[i]);
            if (i < 3) drive(0, 1'b1, 32'(bb_a[i+1]), 32'(bb_b[i+1]), bb_c[i+1]);
            else       drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
            check_state(0, "b2b_acc", 1'b1, 1'b0, prev_sum[0], prev_cout[0]);
            for (int k = 1; k < 8; k++) begin
                tick();
                check_state(0, "b2b_shift", 1'b1, 1'b0, prev_sum[0], prev_cout[0]);
            end
            tick();
            check_state(0, "b2b_res", 1'b0, 1'b1, 32'(t[7:0]), t[8]);
            prev_sum[0]  = 32'(t[7:0]);
            prev_cout[0] = t[8];
            if (i < 3) tick();
        end

        // Random operands at both widths.
        for (int i = 0; i < 1000; i++)
            do_op(0, $urandom, $urandom, 1'($urandom), 1'b0, -1, "rand8");
        for (int i = 0; i < 1000; i++)
            do_op(1, $urandom, $urandom, 1'($urandom), 1'b0, -1, "rand16");
        do_op(1, 32'hFFFF, 32'h0000, 1'b1, 1'b1, -1, "ffff_c1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
